morse_keyer: RTL and testbench
==============================

# morse_keyer

Parametrised Morse element sequencer; successor to the fixed 3-bit-letter LED flasher. It accepts a pattern of up to MAX_LEN dot/dash elements and a length, and drives a single LED output with standard Morse timing (dot 1 unit, dash DASH_UNITS, element space 1 unit, letter gap GAP_UNITS). A busy/done handshake lets an upstream text source stream letters back-to-back. An optional repeat mode loops the latched letter. It sits between the letter encoder (switches/ROM) and the board LED.

## Interface
- UNIT_CYCLES, default 25_000_000: clock cycles per Morse unit; must be ≥ 2.
- MAX_LEN, default 8: maximum elements per letter.
- DASH_UNITS, default 3: dash length in units.
- GAP_UNITS, default 3: inter-letter gap in units.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  load request; accepted only when busy=0.
- pattern  input  MAX_LEN  element code, bit 0 sent first; 1=dash, 0=dot.
- length  input  $clog2(MAX_LEN+1)  number of elements to send.
- repeat_en  input  1  sampled at end of gap; 1 = resend the latched letter.
- busy  output  1  high from start acceptance until the letter (including gap) completes.
- done  output  1  one-cycle pulse at letter completion.
- led  output  1  registered; high during marks (dot/dash).

## Operation
- States: IDLE, MARK, SPACE, GAP.
- IDLE: led=0, busy=0. On start=1, latch pattern and length (length>MAX_LEN clamps to MAX_LEN), clear the element index, and set busy=1.
  - length=0: go straight to GAP (silent letter gap only).
  - Otherwise go to MARK with the duration taken from pattern[0].
- MARK: led=1 for 1 unit (dot) or DASH_UNITS units (dash). At expiry:
  - If more elements remain → SPACE.
  - Else → GAP.
- SPACE: led=0 for 1 unit, then advance the index → MARK with the next element.
- GAP: led=0 for GAP_UNITS units. At expiry done pulses for 1 cycle.
  - repeat_en=1: index reset, → MARK (or GAP again if length=0); busy stays 1.
  - Else → IDLE with busy=0.
- start while busy=1 is ignored. Pattern, length and mode changes while busy have no effect on the letter in flight.
- Timing uses one unit timer (0..UNIT_CYCLES-1, wraps, emits a unit tick) plus a unit-count register sized for max(DASH_UNITS, GAP_UNITS). Both clear on every state entry.
- Reset low at any clock edge, including mid-letter → IDLE. led=0, busy=0, done=0, counters and latches cleared. No partial completion and no done pulse.

## Timing
- Reset values: led=0, busy=0, done=0.
- start sampled high at edge k (IDLE): busy=1 and led=1 after edge k. Load-to-LED latency is 1 cycle.
- Each state lasts exactly units×UNIT_CYCLES cycles; no extra cycles between consecutive states.
- done and the busy fall (non-repeat) occur at the same edge, at the end of the final GAP cycle.
- A start presented in the same cycle as done (busy still 1) is ignored. The earliest new start is accepted the cycle after busy falls, so the back-to-back letter spacing is exactly GAP_UNITS units + 1 cycle.
- Busy duration = Σmarks + (length−1) spaces + GAP_UNITS units, in units × UNIT_CYCLES.

## Structure
- Shared package morse_pkg holds:
  - The state enum (IDLE/MARK/SPACE/GAP).
  - Element encoding constants (DOT=0, DASH=1).
  - A function returning units per element.
- Sub-module morse_unit_timer: parameter UNIT_CYCLES; inputs clk, reset, clear; output unit_tick.
- The FSM, element index, unit-count and latches stay in morse_keyer.

## Test plan
All scenarios use UNIT_CYCLES=4, MAX_LEN=8, DASH_UNITS=3, GAP_UNITS=3.
- "A" (pattern=8'b10, length=2), start 1 cycle → led high 4, low 4, high 12, low 12 cycles; done pulses once; busy high exactly 32 cycles.
- length=0, start → led stays 0; busy high 12 cycles; done pulses once.
- Start pulses every cycle during "E" (pattern=0, length=1) → only the first is accepted; busy=16 cycles; a single done.
- repeat_en=1 with "T" (pattern=1, length=1) → led pattern of 12 high / 12 low repeats with done every 24 cycles. Drop repeat_en → busy falls after the next gap.
- reset low during the second element of "A" → the next cycle has led=0, busy=0, done=0, and no done pulse follows. A new start works normally.
- length=9 (>MAX_LEN) with pattern=8'hFF → 8 dashes sent, then gap, then done.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and helpers for the Morse keyer: FSM state encoding,
// element codes and the per-element duration lookup.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  function automatic int unsigned elem_units(input logic elem, input int unsigned dash_units);
    case (elem)
      ELEM_DOT:  return 32'd1;
      ELEM_DASH: return dash_units;
      default:   return 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running Morse unit timer: counts 0..UNIT_CYCLES-1 and flags the last
// cycle of each unit. clear_i restarts the unit on the following cycle.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  output logic unit_tick_o
);

  localparam int unsigned TW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign unit_tick_o = (cnt_q == TW'(UNIT_CYCLES - 1));

  // Next count: restart on clear or at end of unit, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || unit_tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse element sequencer: latches a dot/dash pattern and drives the LED with
// mark/space/gap timing, reporting busy and a done pulse per letter.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned DASH_UNITS  = 3,
  parameter int unsigned GAP_UNITS   = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         start_i,
  input  logic [MAX_LEN-1:0]           pattern_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] length_i,
  input  logic                         repeat_en_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         led_o
);

  localparam int unsigned LW   = $clog2(MAX_LEN + 1);
  localparam int unsigned IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned MAXU = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int unsigned CW   = $clog2(MAXU + 1);

  state_e               state_q;
  logic [MAX_LEN-1:0]   pat_q;
  logic [LW-1:0]        len_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        ucnt_q;
  logic [CW-1:0]        ucnt_d;
  logic                 led_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 unit_tick_s;
  logic                 timer_clear_s;
  logic [CW-1:0]        target_s;
  logic                 expire_s;
  logic                 more_s;
  logic [LW-1:0]        len_clamp_s;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (timer_clear_s),
    .unit_tick_o(unit_tick_s)
  );

  // Duration of the current state in units.
  always_comb begin
    target_s = CW'(1);
    case (state_q)
      ST_MARK:  target_s = CW'(elem_units(pat_q[idx_q], DASH_UNITS));
      ST_SPACE: target_s = CW'(1);
      ST_GAP:   target_s = CW'(GAP_UNITS);
      default:  target_s = CW'(1);
    endcase
  end

  assign expire_s      = unit_tick_s && (ucnt_q == target_s - CW'(1));
  assign more_s        = (LW'(idx_q) + LW'(1)) < len_q;
  assign len_clamp_s   = (length_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : length_i;
  // Holding the timer cleared in IDLE makes the first unit start aligned with acceptance.
  assign timer_clear_s = (state_q == ST_IDLE) || expire_s;

  // Unit counter next value: restarts on every state entry.
  always_comb begin
    ucnt_d = ucnt_q;
    if (timer_clear_s) begin
      ucnt_d = '0;
    end else if (unit_tick_s) begin
      ucnt_d = ucnt_q + CW'(1);
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Unit counter register.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  // Letter sequencing FSM with registered led/busy/done.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            pat_q  <= pattern_i;
            len_q  <= len_clamp_s;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (len_clamp_s == LW'(0)) begin
              state_q <= ST_GAP;
              led_q   <= 1'b0;
            end else begin
              state_q <= ST_MARK;
              led_q   <= 1'b1;
            end
          end
        end
        ST_MARK: begin
          if (expire_s) begin
            led_q   <= 1'b0;
            state_q <= more_s ? ST_SPACE : ST_GAP;
          end
        end
        ST_SPACE: begin
          if (expire_s) begin
            idx_q   <= idx_q + IW'(1);
            led_q   <= 1'b1;
            state_q <= ST_MARK;
          end
        end
        ST_GAP: begin
          if (expire_s) begin
            done_q <= 1'b1;
            if (repeat_en_i) begin
              idx_q   <= '0;
              state_q <= (len_q == LW'(0)) ? ST_GAP : ST_MARK;
              led_q   <= (len_q != LW'(0));
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: stimulus queues the expected per-letter
// profile, a monitor measures each letter and compares on every done pulse.
module tb_morse_keyer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] length;
  logic       repeat_en;
  logic       busy;
  logic       done;
  logic       led;

  typedef struct {
    int cyc;
    int high;
    int marks;
    int first;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  morse_keyer #(
    .UNIT_CYCLES(4),
    .MAX_LEN    (8),
    .DASH_UNITS (3),
    .GAP_UNITS  (3)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .start_i    (start),
    .pattern_i  (pattern),
    .length_i   (length),
    .repeat_en_i(repeat_en),
    .busy_o     (busy),
    .done_o     (done),
    .led_o      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measure each letter, compare against the scoreboard on done.
  initial begin
    int cyc, high, marks, run, first, last;
    logic prev;
    exp_t e;
    cyc = 0; high = 0; marks = 0; run = 0; first = 0; last = 0; prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n !== 1'b1) begin
        cyc = 0; high = 0; marks = 0; run = 0; first = 0; last = 0; prev = 1'b0;
      end else begin
        if (done === 1'b1) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("letter_cycles", cyc, e.cyc);
            check("led_high_cycles", high, e.high);
            check("mark_count", marks, e.marks);
            check("first_mark_len", first, e.first);
            check("last_mark_len", last, e.last);
          end
          cyc = 0; high = 0; marks = 0; run = 0; first = 0; last = 0;
        end
        if (busy === 1'b1) begin
          cyc++;
          if (led === 1'b1) begin
            high++;
            run++;
            if (!prev) marks++;
          end else if (prev) begin
            if (first == 0) first = run;
            last = run;
            run  = 0;
          end
        end
        prev = led;
      end
    end
  end

  task automatic push_exp(input int c, input int h, input int m, input int f, input int l);
    exp_t e;
    e.cyc = c; e.high = h; e.marks = m; e.first = f; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] p, input logic [3:0] l,
                      input int c, input int h, input int m, input int f, input int la);
    @(negedge clk);
    pattern = p;
    length  = l;
    start   = 1'b1;
    push_exp(c, h, m, f, la);
    @(posedge clk);
    #1;
    check("busy_after_start", int'(busy), 1);
    check("led_load_latency", int'(led), (l != 4'd0) ? 1 : 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy === 1'b1 && n < budget);
    if (busy === 1'b1) check("idle_timeout", 1, 0);
  endtask

  initial begin
    int base;
    int n;
    reset_n = 1'b0; start = 1'b0; pattern = 8'd0; length = 4'd0; repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset_n = 1'b1;

    // "A": dot (4) space (4) dash (12) gap (12)
    send(8'b10, 4'd2, 32, 16, 2, 4, 12);
    wait_idle(100);

    // Silent letter: gap only
    send(8'h00, 4'd0, 12, 0, 0, 0, 0);
    wait_idle(100);

    // "E" with start held through the done cycle: only the first is accepted
    @(negedge clk);
    pattern = 8'h00; length = 4'd1; start = 1'b1;
    push_exp(16, 4, 1, 4, 4);
    @(negedge clk);
    pattern = 8'hFF; length = 4'd3;
    repeat (16) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("start_ignored_at_done", int'(busy), 0);

    // "T" in repeat mode: three letters, repeat dropped during the third
    @(negedge clk);
    repeat_en = 1'b1;
    base = done_cnt;
    send(8'h01, 4'd1, 24, 12, 1, 12, 12);
    push_exp(24, 12, 1, 12, 12);
    push_exp(24, 12, 1, 12, 12);
    n = 0;
    while (done_cnt < base + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("repeat_second_done_seen", (done_cnt >= base + 2) ? 1 : 0, 1);
    @(negedge clk);
    repeat_en = 1'b0;
    wait_idle(200);
    @(negedge clk);
    check("repeat_done_count", done_cnt - base, 3);

    // Reset in the middle of the dash of "A"
    send(8'b10, 4'd2, 32, 16, 2, 4, 12);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    base = done_cnt;
    @(posedge clk);
    #1;
    check("midreset_led", int'(led), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", done_cnt - base, 0);
    send(8'b10, 4'd2, 32, 16, 2, 4, 12);
    wait_idle(100);

    // Over-long length clamps to 8 dashes
    send(8'hFF, 4'd9, 136, 96, 8, 12, 12);
    wait_idle(300);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
